// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath -- single-bus CPU datapath: 16 GPRs, HI/LO, PC, IR, MDR, MAR, Y,
// 64-bit Z and a combinational ALU fed by Y (A) and the bus (B).
//
// Ports
//   clk, reset        : clock, synchronous active-high reset (clears all regs)
//   R*out..MARout     : bus-source selects, priority R0out first, MARout last
//   Read              : MDR loads IN instead of the bus
//   IncPC             : PC loads PC+1 instead of the bus
//   AND..NOT          : ALU op selects, priority AND first, NOT last
//   R*in..MDRin       : register load enables
//   IN [31:0]         : memory/input data word (also a bus source via INout)
//   BusMuxOut [31:0]  : current bus value (combinational)
//   PC [31:0]         : program counter register
//
// Configuration
//   DATAPATH_DIV_EN   : when defined, the signed divider is built; otherwise
//                       DIV yields Z = 0.
// -----------------------------------------------------------------------------
module datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout,
  input  logic        INout, Cout, Yout, MARout,
  input  logic        Read,
  input  logic        IncPC,
  input  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic [31:0] IN,
  output logic [31:0] BusMuxOut,
  output logic [31:0] PC
);

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_pc, r_ir, r_mdr, r_mar, r_y;
  logic [63:0] r_z;

  logic [15:0] w_rout, w_rin;
  logic [31:0] w_bus;
  logic [31:0] w_c;
  logic [63:0] w_alu;
  logic [63:0] w_div;

  assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Immediate field of the instruction, sign-extended from bit 18.
  assign w_c = {{13{r_ir[18]}}, r_ir[18:0]};

  // Bus mux: lowest-numbered GPR wins, then the fixed source order below.
  always_comb begin
    w_bus = 32'h0;
    if (|w_rout) begin
      for (int i = 15; i >= 0; i--) begin
        if (w_rout[i]) w_bus = r_gpr[i];
      end
    end else if (HIout)    w_bus = r_hi;
    else if (LOout)        w_bus = r_lo;
    else if (Zhighout)     w_bus = r_z[63:32];
    else if (Zlowout)      w_bus = r_z[31:0];
    else if (PCout)        w_bus = r_pc;
    else if (IRout)        w_bus = r_ir;
    else if (MDRout)       w_bus = r_mdr;
    else if (INout)        w_bus = IN;
    else if (Cout)         w_bus = w_c;
    else if (Yout)         w_bus = r_y;
    else if (MARout)       w_bus = r_mar;
  end

  assign BusMuxOut = w_bus;
  assign PC        = r_pc;

`ifdef DATAPATH_DIV_EN
  logic [31:0] w_quo, w_rem;
  always_comb begin
    w_quo = 32'h0;
    w_rem = 32'h0;
    if (w_bus == 32'h0) begin
      w_quo = 32'hFFFF_FFFF;
      w_rem = r_y;
    end else if (r_y == 32'h8000_0000 && w_bus == 32'hFFFF_FFFF) begin
      // Only overflowing case: quotient wraps to the dividend, remainder 0.
      w_quo = r_y;
    end else begin
      w_quo = $signed(r_y) / $signed(w_bus);
      w_rem = $signed(r_y) % $signed(w_bus);
    end
    w_div = {w_rem, w_quo};
  end
`else
  assign w_div = 64'h0;
`endif

  // ALU. Arithmetic runs on 64-bit sign-extended operands so Zhigh holds the
  // sign of the true (non-wrapped) result.
  logic [63:0] w_a_sx, w_b_sx;
  logic [4:0]  w_sh;
  logic [63:0] w_rot_r, w_rot_l;
  logic [31:0] w_sra;

  assign w_a_sx  = {{32{r_y[31]}}, r_y};
  assign w_b_sx  = {{32{w_bus[31]}}, w_bus};
  assign w_sh    = w_bus[4:0];
  assign w_rot_r = {r_y, r_y} >> w_sh;
  assign w_rot_l = {r_y, r_y} << w_sh;
  assign w_sra   = $signed(r_y) >>> w_sh;

  always_comb begin
    w_alu = 64'h0;
    if (AND)       w_alu = {32'h0, r_y & w_bus};
    else if (OR)   w_alu = {32'h0, r_y | w_bus};
    else if (ADD)  w_alu = w_a_sx + w_b_sx;
    else if (SUB)  w_alu = w_a_sx - w_b_sx;
    else if (MUL)  w_alu = w_a_sx * w_b_sx;
    else if (DIV)  w_alu = w_div;
    else if (SHR)  w_alu = {32'h0, r_y >> w_sh};
    else if (SHRA) w_alu = {32'h0, w_sra};
    else if (SHL)  w_alu = {32'h0, r_y << w_sh};
    else if (ROR)  w_alu = {32'h0, w_rot_r[31:0]};
    else if (ROL)  w_alu = {32'h0, w_rot_l[63:32]};
    else if (NEG)  w_alu = 64'h0 - w_b_sx;
    else if (NOT)  w_alu = {32'h0, ~w_bus};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= 32'h0;
      r_hi  <= 32'h0;
      r_lo  <= 32'h0;
      r_pc  <= 32'h0;
      r_ir  <= 32'h0;
      r_mdr <= 32'h0;
      r_mar <= 32'h0;
      r_y   <= 32'h0;
      r_z   <= 64'h0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_rin[i]) r_gpr[i] <= w_bus;
      end
      if (HIin)  r_hi  <= w_bus;
      if (LOin)  r_lo  <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (MARin) r_mar <= w_bus;
      if (Yin)   r_y   <= w_bus;
      if (MDRin) r_mdr <= Read ? IN : w_bus;
      if (PCin)  r_pc  <= IncPC ? r_pc + 32'd1 : w_bus;
      if (Zin)   r_z   <= w_alu;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] rout, rin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC;
  logic [12:0] ops;  // bit 0 = AND ... bit 12 = NOT
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
  logic [31:0] in_d;
  logic [31:0] bus, pc;

  localparam int OpAnd = 0, OpOr = 1, OpAdd = 2, OpSub = 3, OpMul = 4, OpDiv = 5;
  localparam int OpShr = 6, OpShra = 7, OpShl = 8, OpRor = 9, OpRol = 10, OpNeg = 11;
  localparam int OpNot = 12;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .reset(reset),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
    .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC),
    .AND(ops[0]), .OR(ops[1]), .ADD(ops[2]), .SUB(ops[3]), .MUL(ops[4]), .DIV(ops[5]),
    .SHR(ops[6]), .SHRA(ops[7]), .SHL(ops[8]), .ROR(ops[9]), .ROL(ops[10]),
    .NEG(ops[11]), .NOT(ops[12]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .IN(in_d), .BusMuxOut(bus), .PC(pc)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] sb_val[$];
  string       sb_name[$];

  typedef struct {
    logic [12:0] ops;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic logic [12:0] opm(input int i);
    logic [12:0] one;
    one = 13'd1;
    return one << i;
  endfunction

  task automatic clear();
    reset = 1'b0; rout = '0; rin = '0; ops = '0; Read = 1'b0; IncPC = 1'b0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; IRout = 0;
    MDRout = 0; INout = 0; Cout = 0; Yout = 0; MARout = 0;
    HIin = 0; LOin = 0; PCin = 0; IRin = 0; Zin = 0; Yin = 0; MARin = 0; MDRin = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic sb_push(input string name, input logic [31:0] v);
    sb_name.push_back(name);
    sb_val.push_back(v);
  endtask

  // Caller has set one bus select; compare the bus to the oldest expectation.
  task automatic sb_check();
    #1;
    if (sb_val.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got %08h expected <entry>", bus);
    end else begin
      check(sb_name.pop_front(), bus, sb_val.pop_front());
    end
  endtask

  // Load a register path from IN via the bus in one cycle.
  task automatic load_in_gpr(input int r, input logic [31:0] v);
    clear(); in_d = v; INout = 1; rin[r] = 1; tick();
  endtask

  task automatic read_gpr(input int r, input string name, input logic [31:0] exp);
    sb_push(name, exp);
    clear(); rout[r] = 1; sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{opm(OpAdd),  32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000};
    vt[1]  = '{opm(OpSub),  32'h0000_0000, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[2]  = '{opm(OpAnd),  32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000};
    vt[3]  = '{opm(OpOr),   32'h0F00_000F, 32'h0000_0010, 64'h0000_0000_0F00_001F};
    vt[4]  = '{opm(OpMul),  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
`ifdef DATAPATH_DIV_EN
    vt[5]  = '{opm(OpDiv),  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
    vt[6]  = '{opm(OpDiv),  32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF};
`else
    vt[5]  = '{opm(OpDiv),  32'h0000_0007, 32'h0000_0002, 64'h0};
    vt[6]  = '{opm(OpDiv),  32'h0000_0007, 32'h0000_0000, 64'h0};
`endif
    vt[7]  = '{opm(OpShr),  32'h8000_0001, 32'h0000_0001, 64'h0000_0000_4000_0000};
    vt[8]  = '{opm(OpShra), 32'h8000_0001, 32'h0000_0001, 64'h0000_0000_C000_0000};
    vt[9]  = '{opm(OpShl),  32'h8000_0001, 32'h0000_0001, 64'h0000_0000_0000_0002};
    vt[10] = '{opm(OpRor),  32'h8000_0001, 32'h0000_0001, 64'h0000_0000_C000_0000};
    vt[11] = '{opm(OpRol),  32'h8000_0001, 32'h0000_0001, 64'h0000_0000_0000_0003};
    vt[12] = '{opm(OpNeg),  32'h0000_0000, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB};
    vt[13] = '{opm(OpNot),  32'h0000_0000, 32'h0F0F_0000, 64'h0000_0000_F0F0_FFFF};
    vt[14] = '{opm(OpShr),  32'h0000_0021, 32'h0000_0021, 64'h0000_0000_0000_0010};
    vt[15] = '{13'h0,       32'h1234_5678, 32'h0000_0001, 64'h0};
    vt[16] = '{opm(OpAnd) | opm(OpAdd), 32'h0000_0003, 32'h0000_0005, 64'h1};

    // Power-on reset.
    clear(); in_d = 32'h0; reset = 1; tick(); tick(); clear();
    check("rst_pc", pc, 32'h0);
    #1 check("rst_bus_idle", bus, 32'h0);
    read_gpr(0, "rst_r0", 32'h0);

    // Instruction fetch: PC+1, MAR from idle bus, MDR from memory, then IR.
    clear(); in_d = 32'h4A1B_8000; IncPC = 1; PCin = 1; MARin = 1; MDRin = 1; Read = 1;
    tick();
    check("fetch_pc", pc, 32'h1);
    sb_push("fetch_mar", 32'h0);         clear(); MARout = 1; sb_check();
    sb_push("fetch_mdr", 32'h4A1B_8000); clear(); MDRout = 1; sb_check();
    clear(); MDRout = 1; IRin = 1; tick();
    sb_push("fetch_ir", 32'h4A1B_8000);  clear(); IRout = 1; sb_check();
    sb_push("c_pos", 32'h0003_8000);     clear(); Cout = 1; sb_check();

    // Memory -> MDR -> GPR, then Y/SHR into R4.
    clear(); in_d = 32'h22; Read = 1; MDRin = 1; tick();
    clear(); MDRout = 1; rin[3] = 1; tick();
    clear(); in_d = 32'h24; Read = 1; MDRin = 1; tick();
    clear(); MDRout = 1; rin[7] = 1; tick();
    clear(); in_d = 32'h28; Read = 1; MDRin = 1; tick();
    clear(); MDRout = 1; rin[4] = 1; tick();
    read_gpr(4, "r4_loaded", 32'h28);
    clear(); rout[3] = 1; Yin = 1; tick();
    clear(); rout[7] = 1; ops = opm(OpShr); Zin = 1; tick();
    clear(); Zlowout = 1; rin[4] = 1; tick();
    read_gpr(4, "r4_shr", 32'h0000_0002);

    // Negative immediate sign extension.
    clear(); in_d = 32'h0004_0001; INout = 1; IRin = 1; tick();
    sb_push("c_neg", 32'hFFFC_0001); clear(); Cout = 1; sb_check();

    // Bus priority: R0out beats INout; R2out beats R9out.
    load_in_gpr(0, 32'h0000_AAAA);
    load_in_gpr(2, 32'h0000_0222);
    load_in_gpr(9, 32'h0000_0999);
    sb_push("prio_r0_in", 32'h0000_AAAA);
    clear(); in_d = 32'h5555; rout[0] = 1; INout = 1; sb_check();
    sb_push("prio_r2_r9", 32'h0000_0222);
    clear(); rout[2] = 1; rout[9] = 1; sb_check();

    // PC loads from bus, then wraps on increment.
    clear(); in_d = 32'hFFFF_FFFF; INout = 1; PCin = 1; tick();
    check("pc_bus_load", pc, 32'hFFFF_FFFF);
    clear(); PCin = 1; IncPC = 1; tick();
    check("pc_wrap", pc, 32'h0);

    // ALU vector table.
    for (int k = 0; k < NV; k++) begin
      clear(); in_d = vt[k].a; INout = 1; Yin = 1; tick();
      clear(); in_d = vt[k].b; INout = 1; ops = vt[k].ops; Zin = 1;
      sb_push($sformatf("alu%0d_lo", k), vt[k].z[31:0]);
      sb_push($sformatf("alu%0d_hi", k), vt[k].z[63:32]);
      tick();
      clear(); Zlowout = 1; sb_check();
      clear(); Zhighout = 1; sb_check();
    end

    // Reset in the middle of an operation overrides every enable.
    clear(); in_d = 32'h0000_0005; INout = 1; Yin = 1; PCin = 1; tick();
    clear(); in_d = 32'h3; INout = 1; ops = opm(OpAdd); Zin = 1; Yin = 1;
    PCin = 1; IncPC = 1; rin = 16'hFFFF; reset = 1; tick();
    clear();
    check("midop_pc", pc, 32'h0);
    sb_push("midop_zlo", 32'h0); clear(); Zlowout = 1; sb_check();
    sb_push("midop_y",   32'h0); clear(); Yout = 1;    sb_check();
    read_gpr(0, "midop_r0", 32'h0);

    // Reset beats R5in/R6in.
    load_in_gpr(5, 32'h0000_1234);
    read_gpr(5, "r5_loaded", 32'h0000_1234);
    clear(); in_d = 32'hBEEF; INout = 1; rin[5] = 1; rin[6] = 1; PCin = 1; reset = 1; tick();
    clear();
    read_gpr(5, "rst_r5", 32'h0);
    read_gpr(6, "rst_r6", 32'h0);
    check("rst2_pc", pc, 32'h0);
    clear(); #1 check("rst2_bus_idle", bus, 32'h0);

    if (sb_val.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb_val.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
